// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and state encoding for the skid stage
//
// Purpose : default payload widths and the EMPTY/HALF/FULL state encoding.
//           The state value doubles as the occupancy count, so the encoding
//           must stay 0/1/2.
// Ports   : none (package)

package pipe_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int CTRL_W_DEF = 8;

   typedef logic [1:0] state_t;

   localparam state_t ST_EMPTY = 2'd0;
   localparam state_t ST_HALF  = 2'd1;
   localparam state_t ST_FULL  = 2'd2;

endpackage

// File: rtl/pipe_data_reg.sv
// rtl/pipe_data_reg.sv - width-parametrised payload register
//
// Purpose : holds one {ctrl, data} entry of the skid stage.
//           Synchronous clear wins over load so a flush always empties it.
// Ports   : clk     - clock, rising edge
//           rst     - asynchronous active-high reset, forces q_o to zero
//           load_i  - capture d_i on the next rising edge
//           clear_i - zero the register on the next rising edge
//           d_i     - next payload
//           q_o     - held payload

module pipe_data_reg #(
   parameter int W = 40
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         clear_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else if (clear_i) begin
         data_q <= '0;
      end else if (load_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-entry skid buffer pipeline stage
//
// Purpose : registered valid/ready pipeline stage with a skid register so
//           in_ready depends on registered state only, while still moving
//           one instruction per cycle when downstream never stalls.
// Ports   : clk, rst          - clock and asynchronous active-high reset
//           in_valid/in_ready - upstream handshake (in_ready is registered)
//           in_data, in_ctrl  - upstream datapath and control payload
//           flush             - synchronous kill of every held instruction
//           out_valid/out_ready - downstream handshake
//           out_data, out_ctrl  - payload of the oldest held instruction
//           occupancy         - number of held entries, 0..2

module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
);

   localparam int PW = DATA_W + CTRL_W;

   state_t state_q;
   state_t state_d;

   logic in_fire;
   logic out_fire;

   logic          main_load;
   logic          main_clr;
   logic          main_from_skid;
   logic          skid_load;
   logic          skid_clr;
   logic [PW-1:0] main_d;
   logic [PW-1:0] main_q;
   logic [PW-1:0] skid_q;

   // Handshake decode straight from the state register; out_ready never
   // reaches in_ready.
   assign in_ready  = (state_q != ST_FULL);
   assign out_valid = (state_q != ST_EMPTY);

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      main_clr       = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_clr       = 1'b0;

      if (flush) begin
         // An out_fire this cycle has already been consumed downstream;
         // an in_fire this cycle is simply dropped.
         state_d  = ST_EMPTY;
         main_clr = 1'b1;
         skid_clr = 1'b1;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d   = ST_HALF;
                  main_load = 1'b1;
               end
            end

            ST_HALF: begin
               if (in_fire && !out_fire) begin
                  state_d   = ST_FULL;
                  skid_load = 1'b1;
               end else if (out_fire && !in_fire) begin
                  // Zero the main register so a bubble presents all-zero
                  // control and can never trigger a register write.
                  state_d  = ST_EMPTY;
                  main_clr = 1'b1;
               end else if (in_fire && out_fire) begin
                  main_load = 1'b1;
               end
            end

            ST_FULL: begin
               if (out_fire) begin
                  state_d        = ST_HALF;
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
                  skid_clr       = 1'b1;
               end
            end

            default: begin
               // Unreachable encoding: recover to a clean empty stage.
               state_d  = ST_EMPTY;
               main_clr = 1'b1;
               skid_clr = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   assign main_d = main_from_skid ? skid_q : {in_ctrl, in_data};

   pipe_data_reg #(
      .W (PW)
   ) u_main_reg (
      .clk     (clk),
      .rst     (rst),
      .load_i  (main_load),
      .clear_i (main_clr),
      .d_i     (main_d),
      .q_o     (main_q)
   );

   pipe_data_reg #(
      .W (PW)
   ) u_skid_reg (
      .clk     (clk),
      .rst     (rst),
      .load_i  (skid_load),
      .clear_i (skid_clr),
      .d_i     ({in_ctrl, in_data}),
      .q_o     (skid_q)
   );

   // The main register is zero whenever the stage is empty, so the outputs
   // can be driven from it directly.
   assign out_data  = main_q[DATA_W-1:0];
   assign out_ctrl  = main_q[PW-1:DATA_W];
   assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - self-checking bench for pipe_skid_stage

module tb_pipe_skid_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [7:0]  in_ctrl;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [7:0]  out_ctrl;
   logic [1:0]  occupancy;

   int n_checks;
   int n_errors;

   typedef struct {
      logic [31:0] d;
      logic [7:0]  c;
   } ent_t;

   ent_t mq[$];

   pipe_skid_stage #(
      .DATA_W (32),
      .CTRL_W (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [31:0] ed;
      logic [7:0]  ec;
      ed = '0;
      ec = '0;
      if (mq.size() > 0) begin
         ed = mq[0].d;
         ec = mq[0].c;
      end
      chk({tag, ".valid"}, 64'(out_valid), 64'(mq.size() > 0));
      chk({tag, ".occ"},   64'(occupancy), 64'(mq.size()));
      chk({tag, ".ready"}, 64'(in_ready),  64'(mq.size() < 2));
      chk({tag, ".data"},  64'(out_data),  64'(ed));
      chk({tag, ".ctrl"},  64'(out_ctrl),  64'(ec));
   endtask

   // One clock: the queue model applies the stage's rules to the inputs
   // seen at the edge, then all outputs are compared 1 time unit later.
   task automatic step(input string tag);
      bit   m_in_fire;
      bit   m_out_fire;
      ent_t e;
      @(posedge clk);
      m_in_fire  = in_valid && (mq.size() < 2);
      m_out_fire = (mq.size() > 0) && out_ready;
      if (rst) begin
         mq.delete();
      end else begin
         if (m_out_fire) e = mq.pop_front();
         if (flush) begin
            mq.delete();
         end else if (m_in_fire) begin
            e.d = in_data;
            e.c = in_ctrl;
            mq.push_back(e);
         end
      end
      #1;
      check_model(tag);
   endtask

   task automatic drive(input bit v, input logic [31:0] d, input bit rdy);
      in_valid  = v;
      in_data   = d;
      in_ctrl   = d[7:0] ^ 8'hA5;
      out_ready = rdy;
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b0;
      flush     = 1'b0;
      drive(1'b0, 32'h0, 1'b0);

      // Asynchronous reset before any clock edge.
      #1 rst = 1'b1;
      #2;
      chk("rst.valid", 64'(out_valid), 64'd0);
      chk("rst.ready", 64'(in_ready),  64'd1);
      chk("rst.occ",   64'(occupancy), 64'd0);
      chk("rst.data",  64'(out_data),  64'd0);
      chk("rst.ctrl",  64'(out_ctrl),  64'd0);
      step("rst0");
      step("rst1");
      rst = 1'b0;

      // Streaming 1..8 with out_ready high.
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 32'(i), 1'b1);
         step("stream");
         chk("stream.data_const", 64'(out_data), 64'(i));
         chk("stream.occ_const",  64'(occupancy), 64'd1);
      end
      drive(1'b0, 32'h0, 1'b1);
      step("stream.drain");
      chk("stream.empty", 64'(occupancy), 64'd0);

      // Backpressure: A then B with out_ready low.
      drive(1'b1, 32'h11, 1'b0);
      step("bp.a");
      drive(1'b1, 32'h22, 1'b0);
      step("bp.b");
      chk("bp.occ2",   64'(occupancy), 64'd2);
      chk("bp.ready0", 64'(in_ready),  64'd0);
      chk("bp.holdA",  64'(out_data),  64'h11);
      drive(1'b1, 32'h33, 1'b0);
      step("bp.stall");
      chk("bp.stableA", 64'(out_data), 64'h11);
      drive(1'b0, 32'h0, 1'b1);
      step("bp.pop1");
      chk("bp.outB",   64'(out_data), 64'h22);
      chk("bp.ready1", 64'(in_ready), 64'd1);
      step("bp.pop2");
      chk("bp.empty", 64'(out_valid), 64'd0);

      // Flush while FULL with a valid input in the same cycle.
      drive(1'b1, 32'h44, 1'b0);
      step("fl.a");
      drive(1'b1, 32'h55, 1'b0);
      step("fl.b");
      drive(1'b1, 32'h99, 1'b0);
      flush = 1'b1;
      step("fl.flush");
      flush = 1'b0;
      chk("fl.occ",   64'(occupancy), 64'd0);
      chk("fl.valid", 64'(out_valid), 64'd0);
      chk("fl.ctrl",  64'(out_ctrl),  64'd0);
      drive(1'b0, 32'h0, 1'b1);
      step("fl.after");
      chk("fl.no99", 64'(out_valid), 64'd0);

      // Simultaneous in_fire and out_fire while HALF.
      drive(1'b1, 32'hA, 1'b0);
      step("sim.a");
      drive(1'b1, 32'hB, 1'b1);
      step("sim.both");
      chk("sim.occ",  64'(occupancy), 64'd1);
      chk("sim.data", 64'(out_data),  64'hB);
      drive(1'b0, 32'h0, 1'b1);
      step("sim.drain");

      // Reset pulsed mid-cycle while HALF holding 0xDEADBEEF.
      drive(1'b1, 32'hDEADBEEF, 1'b0);
      step("ar.load");
      chk("ar.held", 64'(out_data), 64'hDEADBEEF);
      drive(1'b0, 32'h0, 1'b0);
      #3 rst = 1'b1;
      #1;
      mq.delete();
      chk("ar.valid", 64'(out_valid), 64'd0);
      chk("ar.data",  64'(out_data),  64'd0);
      chk("ar.occ",   64'(occupancy), 64'd0);
      chk("ar.ready", 64'(in_ready),  64'd1);
      step("ar.hold");
      rst = 1'b0;
      drive(1'b1, 32'h5, 1'b1);
      step("ar.first");
      chk("ar.first5", 64'(out_data), 64'h5);
      drive(1'b0, 32'h0, 1'b1);
      step("ar.drain");

      // Random valid/stall/flush traffic against the queue model.
      for (int cyc = 0; cyc < 10000; cyc++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = $urandom;
         in_ctrl   = 8'($urandom);
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 63) == 0);
         step("rnd");
      end
      flush    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      step("rnd.drain1");
      step("rnd.drain2");
      chk("rnd.final_empty", 64'(occupancy), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter: DATA_W, 32, width of the datapath payload (ALU result, memory data, and similar).
REQ-002 Parameter: CTRL_W, 8, width of the control payload (RegW, Reg_Src, WBdst, and similar).
REQ-003 Port: clk input 1, clock; all state updates on the rising edge.
REQ-004 Port: rst input 1, reset; asynchronous, active-high.
REQ-005 Port: in_valid input 1, the upstream stage presents a valid instruction.
REQ-006 Port: in_ready output 1, the stage accepts input this cycle; registered.
REQ-007 Port: in_data input DATA_W, upstream datapath payload.
REQ-008 Port: in_ctrl input CTRL_W, upstream control payload.
REQ-009 Port: flush input 1, synchronous kill of all held instructions.
REQ-010 Port: out_valid output 1, the stage presents a valid instruction downstream.
REQ-011 Port: out_ready input 1, downstream accepts this cycle.
REQ-012 Port: out_data output DATA_W, held datapath payload.
REQ-013 Port: out_ctrl output CTRL_W, held control payload.
REQ-014 Port: occupancy output 2, number of held entries (0..2).

Function
REQ-015 Transfer definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-016 The state machine has three states: EMPTY (occ 0), HALF (occ 1), and FULL (occ 2); occupancy equals the state encoding.
REQ-017 EMPTY: in_fire -> HALF with the main register loaded; otherwise the state holds.
REQ-018 HALF transitions:
- in_fire & !out_fire -> FULL, with the skid register loaded.
- out_fire & !in_fire -> EMPTY.
- Both fire -> HALF, with the main register loaded from the input.
REQ-019 FULL: out_fire -> HALF, with main <= skid; otherwise the state holds; no input is accepted.
REQ-020 in_ready = 1 in EMPTY and HALF and 0 in FULL; it is derived from registered state only, with no combinational path from out_ready.
REQ-021 out_valid = 1 in HALF and FULL; out_data/out_ctrl always come from the main register.
REQ-022 Timing:
- Latency: in_fire in cycle N -> out_valid with that payload in cycle N+1.
- Sustained throughput: 1 instruction/cycle while out_ready = 1.
REQ-023 While out_valid & !out_ready, out_data/out_ctrl remain bit-stable.
REQ-024 Whenever out_valid = 0, out_data and out_ctrl are all-zero, so a bubble never asserts a register write.
REQ-025 flush has highest priority: the next state is EMPTY and both registers are zeroed. An in_fire in the same cycle is discarded. An out_fire in the same cycle completes normally, because its data is already presented.
REQ-026 Ordering is strictly FIFO; no instruction is duplicated or lost except by flush.

Reset
REQ-027 While rst = 1 the outputs are forced immediately, independent of clk:
- State = EMPTY.
- Main and skid registers = 0.
- out_valid = 0, out_data = 0, out_ctrl = 0.
- occupancy = 0.
- in_ready = 1.
REQ-028 Reset asserted mid-operation discards all held entries; the first in_fire after deassertion is the first output.

Structure
REQ-029 Shared package pipe_pkg contains the state type (EMPTY/HALF/FULL) and the default DATA_W/CTRL_W constants.
REQ-030 Sub-module pipe_data_reg is a width-parametrised register with async reset, load enable and synchronous clear. It is instantiated twice, once for main and once for skid, each carrying {ctrl, data}.

Verification
REQ-031 Streaming: in_valid = 1 with data 1..8, out_ready = 1 -> outputs 1..8 on consecutive cycles, each one cycle after acceptance; occupancy stays 1.
REQ-032 Backpressure:
- Stimulus: out_ready = 0, present data A = 0x11 then B = 0x22.
- Response: occupancy reaches 2, in_ready = 0, and out_data holds 0x11.
- Follow-up: out_ready = 1 -> 0x11 then 0x22 appear, and in_ready returns to 1 after the first out_fire.
REQ-033 Flush in FULL with in_valid = 1 -> next cycle occupancy 0, out_valid 0, out_ctrl 0; the input in the flush cycle never appears at the output.
REQ-034 Async reset pulsed mid-cycle in HALF holding 0xDEADBEEF -> out_valid/out_data drop to 0 before the next edge; subsequent data 0x5 emerges first.
REQ-035 Simultaneous in_fire and out_fire in HALF -> occupancy stays 1 and out_data updates to the new input the next cycle.
REQ-036 Random stall/valid stimulus over 10k cycles against a scoreboard -> in-order, lossless delivery; out_ctrl = 0 whenever out_valid = 0.
